// File: rtl/game_pkg.sv
// Shared types for the 2048-style move sequencer: tile/line/board layout,
// move directions, sequencer states and line gather/scatter helpers.
package game_pkg;

  localparam int TILE_W = 12;

  typedef logic [TILE_W-1:0] tile_t;
  typedef tile_t [3:0]       line_t;   // element 0 is the edge tiles slide toward
  typedef line_t [3:0]       board_t;  // board[row][col]

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MOVE  = 3'd1,
    ST_SPAWN = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  // Gather line k so that element 0 sits on the edge the move pushes toward.
  function automatic line_t get_line(board_t b, dir_t d, logic [1:0] k);
    line_t      l;
    logic [1:0] jj;
    l = '0;
    for (int j = 0; j < 4; j++) begin
      jj = 2'(j);
      case (d)
        DIR_LEFT:  l[j] = b[k][jj];
        DIR_RIGHT: l[j] = b[k][~jj];
        DIR_UP:    l[j] = b[jj][k];
        default:   l[j] = b[~jj][k];
      endcase
    end
    return l;
  endfunction

  function automatic board_t put_line(board_t b, dir_t d, logic [1:0] k, line_t l);
    board_t     r;
    logic [1:0] jj;
    r = b;
    for (int j = 0; j < 4; j++) begin
      jj = 2'(j);
      case (d)
        DIR_LEFT:  r[k][jj]  = l[j];
        DIR_RIGHT: r[k][~jj] = l[j];
        DIR_UP:    r[jj][k]  = l[j];
        default:   r[~jj][k] = l[j];
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/line_merge.sv
// Combinational slide of one 4-tile line: compress, merge equal neighbours
// once from element 0, compress again. Reports change and total merged value.
module line_merge
  import game_pkg::*;
(
  input  line_t       line_in,
  output line_t       line_out,
  output logic        changed,
  output logic [12:0] merge_total
);

  line_t       packed_in;
  line_t       merged;
  logic [2:0]  k_a;
  logic [2:0]  k_b;
  logic        skip;
  logic [12:0] sum13;

  always_comb begin
    packed_in   = '0;
    merged      = '0;
    line_out    = '0;
    merge_total = '0;
    k_a         = '0;
    k_b         = '0;
    skip        = 1'b0;
    sum13       = '0;

    for (int i = 0; i < 4; i++) begin
      if (line_in[i] != '0) begin
        packed_in[k_a[1:0]] = line_in[i];
        k_a = k_a + 3'd1;
      end
    end

    // A tile produced by a merge is never merged again in the same move.
    merged = packed_in;
    for (int i = 0; i < 3; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (merged[i] != '0 && merged[i] == merged[i+1]) begin
        sum13       = {1'b0, merged[i]} + {1'b0, merged[i+1]};
        merged[i]   = sum13[12] ? 12'hFFF : sum13[11:0];
        merged[i+1] = '0;
        merge_total = merge_total + {1'b0, merged[i]};
        skip        = 1'b1;
      end
    end

    for (int i = 0; i < 4; i++) begin
      if (merged[i] != '0) begin
        line_out[k_b[1:0]] = merged[i];
        k_b = k_b + 3'd1;
      end
    end

    changed = (line_out != line_in);
  end

endmodule

// File: rtl/move_sequencer.sv
// 4x4 tile-game move sequencer: slides one line per cycle, spawns a tile via
// LFSR scan, then checks win/lose. Define GAME_SCORE_EN to add the score output.
module move_sequencer
  import game_pkg::*;
#(
  parameter logic [11:0] WIN_VALUE = 12'd2048,
  parameter logic [7:0]  LFSR_SEED = 8'hB4
) (
  input  logic       clk,
  input  logic       rst,
  input  board_t     init_matrix,
  input  logic       move_valid,
  input  logic [1:0] move_dir,
  output logic       move_ready,
  output board_t     matrix_q,
  output logic       busy,
  output logic       move_done,
  output logic       win,
  output logic       lose,
`ifdef GAME_SCORE_EN
  output logic [15:0] score,
`endif
  output seq_state_t state_dbg
);

  // Handshake: a move is taken on the rising edge where move_valid && move_ready;
  // move_ready is high only in IDLE with no game-over; other requests are dropped.

  seq_state_t  state, state_next;
  dir_t        dir_q;
  logic [1:0]  line_idx;
  logic        changed_q;
  logic [7:0]  lfsr;
  logic [7:0]  lfsr_next;
  logic [3:0]  scan_idx;
  logic [3:0]  scan_cnt;
  logic        accept;

  line_t       cur_line;
  line_t       new_line;
  logic        line_chg;
  logic [12:0] line_sum;

  logic        spawn_hit;
  logic        any_win;
  logic        any_zero;
  logic        any_pair;

  line_merge u_line_merge (
    .line_in     (cur_line),
    .line_out    (new_line),
    .changed     (line_chg),
    .merge_total (line_sum)
  );

  always_comb begin
    cur_line   = get_line(matrix_q, dir_q, line_idx);
    lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    move_ready = (state == ST_IDLE) && !win && !lose;
    accept     = move_valid && move_ready;
    busy       = (state != ST_IDLE);
    move_done  = (state == ST_DONE);
    state_dbg  = state;
    spawn_hit  = (matrix_q[scan_idx[3:2]][scan_idx[1:0]] == '0);
  end

  always_comb begin
    any_win  = 1'b0;
    any_zero = 1'b0;
    any_pair = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (matrix_q[r][c] == WIN_VALUE) any_win = 1'b1;
        if (matrix_q[r][c] == '0) any_zero = 1'b1;
        if (c < 3 && matrix_q[r][c] == matrix_q[r][c+1]) any_pair = 1'b1;
        if (r < 3 && matrix_q[r][c] == matrix_q[r+1][c]) any_pair = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_MOVE;
      ST_MOVE:  if (line_idx == 2'd3) state_next = (changed_q || line_chg) ? ST_SPAWN : ST_CHECK;
      // The scan-count bound only matters if a full board somehow reaches SPAWN.
      ST_SPAWN: if (spawn_hit || scan_cnt == 4'd15) state_next = ST_CHECK;
      ST_CHECK: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      matrix_q  <= init_matrix;
      lfsr      <= LFSR_SEED;
      dir_q     <= DIR_UP;
      line_idx  <= '0;
      changed_q <= 1'b0;
      scan_idx  <= '0;
      scan_cnt  <= '0;
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      lfsr <= lfsr_next;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dir_q     <= dir_t'(move_dir);
            line_idx  <= '0;
            changed_q <= 1'b0;
          end
        end
        ST_MOVE: begin
          matrix_q  <= put_line(matrix_q, dir_q, line_idx, new_line);
          changed_q <= changed_q | line_chg;
          line_idx  <= line_idx + 2'd1;
          scan_idx  <= lfsr[3:0];
          scan_cnt  <= '0;
        end
        ST_SPAWN: begin
          if (spawn_hit) begin
            matrix_q[scan_idx[3:2]][scan_idx[1:0]] <= (lfsr[7:4] == 4'd0) ? 12'd4 : 12'd2;
          end else begin
            scan_idx <= scan_idx + 4'd1;
            scan_cnt <= scan_cnt + 4'd1;
          end
        end
        ST_CHECK: begin
          if (any_win)                    win  <= 1'b1;
          else if (!any_zero && !any_pair) lose <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef GAME_SCORE_EN
  logic [16:0] score_sum;
  assign score_sum = {1'b0, score} + {4'd0, line_sum};

  always_ff @(posedge clk) begin
    if (rst)                   score <= '0;
    else if (state == ST_MOVE) score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: hand-built boards, expected results
// computed by hand, immediate assertions at each comparison.
module tb_move_sequencer;
  import game_pkg::*;

  logic       clk;
  logic       rst;
  board_t     init_matrix;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       move_ready;
  board_t     matrix_q;
  logic       busy;
  logic       move_done;
  logic       win;
  logic       lose;
`ifdef GAME_SCORE_EN
  logic [15:0] score;
`endif
  seq_state_t state_dbg;

  int checks   = 0;
  int failures = 0;

  move_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .init_matrix (init_matrix),
    .move_valid  (move_valid),
    .move_dir    (move_dir),
    .move_ready  (move_ready),
    .matrix_q    (matrix_q),
    .busy        (busy),
    .move_done   (move_done),
    .win         (win),
    .lose        (lose),
`ifdef GAME_SCORE_EN
    .score       (score),
`endif
    .state_dbg   (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input board_t b);
    @(negedge clk);
    init_matrix = b;
    rst         = 1'b1;
    move_valid  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Cycles are counted from the accepting edge to the cycle showing move_done.
  task automatic run_move(input logic [1:0] d, output int cyc);
    @(negedge clk);
    move_valid = 1'b1;
    move_dir   = d;
    @(negedge clk);
    move_valid = 1'b0;
    cyc = 1;
    while (!move_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // 1 when act equals exp except for exactly one cell that was empty in exp
  // and now holds a freshly spawned 2 or 4.
  function automatic logic spawn_ok(board_t exp, board_t act);
    int diffs;
    logic good;
    diffs = 0;
    good  = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (act[r][c] != exp[r][c]) begin
          diffs++;
          if (exp[r][c] != '0 || !(act[r][c] == 12'd2 || act[r][c] == 12'd4)) good = 1'b0;
        end
    return good && (diffs == 1);
  endfunction

  board_t b;
  board_t e;
  int     cyc;
  int     pulses;

  initial begin
    rst         = 1'b1;
    init_matrix = '0;
    move_valid  = 1'b0;
    move_dir    = 2'b00;

    // Row [2,2,4,0] slid left
    b = '0;
    b[0][0] = 12'd2; b[0][1] = 12'd2; b[0][2] = 12'd4;
    do_reset(b);
    chk("reset_matrix", matrix_q, b);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", move_done, 1'b0);
    chk("reset_win_lose", {win, lose}, 2'b00);
    chk("reset_ready", move_ready, 1'b1);
    chk("reset_state", state_dbg, ST_IDLE);
`ifdef GAME_SCORE_EN
    chk("reset_score", score, 16'd0);
`endif
    run_move(2'b10, cyc);
    e = '0;
    e[0][0] = 12'd4; e[0][1] = 12'd4;
    chk("left_spawn_board", spawn_ok(e, matrix_q), 1'b1);
    chk("left_latency_range", (cyc >= 6 && cyc <= 21), 1'b1);
    chk("left_win_lose", {win, lose}, 2'b00);
`ifdef GAME_SCORE_EN
    chk("left_score", score, 16'd4);
`endif

    // Row [2,2,2,2] slid right: two merges, no chained merge
    b = '0;
    b[1] = {12'd2, 12'd2, 12'd2, 12'd2};
    do_reset(b);
    run_move(2'b11, cyc);
    e = '0;
    e[1][2] = 12'd4; e[1][3] = 12'd4;
    chk("right_spawn_board", spawn_ok(e, matrix_q), 1'b1);
`ifdef GAME_SCORE_EN
    chk("right_score", score, 16'd8);
`endif

    // Already compressed: no change, no spawn, fixed 6-cycle latency
    b = '0;
    b[0][0] = 12'd2; b[0][1] = 12'd4; b[1][0] = 12'd8;
    do_reset(b);
    @(negedge clk);
    move_valid = 1'b1;
    move_dir   = 2'b10;
    @(negedge clk);
    move_valid = 1'b0;
    chk("nochange_busy", busy, 1'b1);
    chk("nochange_ready_low", move_ready, 1'b0);
    cyc = 1;
    while (!move_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("nochange_board", matrix_q, b);
    chk("nochange_latency", cyc, 6);
    @(negedge clk);
    chk("nochange_done_pulse", move_done, 1'b0);
    chk("nochange_back_idle", state_dbg, ST_IDLE);

    // Column slide up: col3 rows [0,2,0,2] -> [4,0,0,0]
    b = '0;
    b[1][3] = 12'd2; b[3][3] = 12'd2;
    do_reset(b);
    run_move(2'b00, cyc);
    e = '0;
    e[0][3] = 12'd4;
    chk("up_spawn_board", spawn_ok(e, matrix_q), 1'b1);

    // Column slide down: col0 rows [4,0,4,8] -> [0,0,8,8]
    b = '0;
    b[0][0] = 12'd4; b[2][0] = 12'd4; b[3][0] = 12'd8;
    do_reset(b);
    run_move(2'b01, cyc);
    e = '0;
    e[2][0] = 12'd8; e[3][0] = 12'd8;
    chk("down_spawn_board", spawn_ok(e, matrix_q), 1'b1);
`ifdef GAME_SCORE_EN
    chk("down_score", score, 16'd8);
`endif

    // 0x800+0x800 overflows 12 bits and clamps to 0xFFF
    b = '0;
    b[2][0] = 12'h800; b[2][1] = 12'h800;
    do_reset(b);
    run_move(2'b10, cyc);
    e = '0;
    e[2][0] = 12'hFFF;
    chk("sat_spawn_board", spawn_ok(e, matrix_q), 1'b1);
    chk("sat_no_win", win, 1'b0);
`ifdef GAME_SCORE_EN
    chk("sat_score", score, 16'h0FFF);
`endif

    // 1024+1024 reaches the win tile; further requests are refused
    b = '0;
    b[0][0] = 12'd1024; b[0][1] = 12'd1024;
    do_reset(b);
    run_move(2'b10, cyc);
    chk("win_tile", matrix_q[0][0], 12'd2048);
    chk("win_flags", {win, lose}, 2'b10);
    chk("win_ready", move_ready, 1'b0);
    e = matrix_q;
    @(negedge clk);
    move_valid = 1'b1;
    move_dir   = 2'b11;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (move_done || busy) pulses++;
    end
    move_valid = 1'b0;
    chk("win_ignored_activity", pulses, 0);
    chk("win_board_frozen", matrix_q, e);
    chk("win_ready_stays_low", move_ready, 1'b0);

    // Checkerboard of 2/4: nothing moves, no merges possible -> lose
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = ((r + c) % 2 == 1) ? 12'd4 : 12'd2;
    do_reset(b);
    run_move(2'b10, cyc);
    chk("lose_latency", cyc, 6);
    chk("lose_flags", {win, lose}, 2'b01);
    chk("lose_board", matrix_q, b);
    @(negedge clk);
    move_valid = 1'b1;
    move_dir   = 2'b00;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (move_done || busy) pulses++;
    end
    move_valid = 1'b0;
    chk("lose_ignored_activity", pulses, 0);

    // Reset landing on the second MOVE cycle aborts the move cleanly
    b = '0;
    b[0][0] = 12'd2; b[0][1] = 12'd2; b[0][2] = 12'd4;
    do_reset(b);
    @(negedge clk);
    move_valid = 1'b1;
    move_dir   = 2'b10;
    @(negedge clk);
    move_valid = 1'b0;
    chk("abort_first_move_cycle", state_dbg, ST_MOVE);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_matrix", matrix_q, b);
    chk("abort_state", state_dbg, ST_IDLE);
    chk("abort_busy", busy, 1'b0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (move_done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    chk("abort_board_kept", matrix_q, b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
